// File: rtl/lock_pkg.sv
// Shared types and width helpers for the lock-sequence controller.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    COMPARE,
    UNLOCKED,
    STORE_ENTRY,
    LOCKOUT
  } lock_state_t;

  // The timer is loaded with (cycles - 1), so clog2 of the largest period is enough.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_edge.sv
// Registered rising-edge detector for one debounced button level.
module button_edge (
  input  logic clk,
  input  logic system_reset_n,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  // prev resets high so a button held through reset never produces an event
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      prev_reg <= 1'b1;
      rise     <= 1'b0;
    end else begin
      prev_reg <= level;
      rise     <= level & ~prev_reg;
    end
  end

endmodule

// File: rtl/lock_seq_ctrl.sv
// Lock-sequence controller: code entry, internal compare, unlock/lockout timing
// and code change, all driven by one shared down-counter.
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int                               CODE_DIGITS    = 4,
  parameter int                               DIGIT_W        = 4,
  parameter logic [CODE_DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                               MAX_ATTEMPTS   = 3,
  parameter int                               UNLOCK_CYCLES  = 1000,
  parameter int                               LOCKOUT_CYCLES = 5000,
  parameter int                               ENTRY_TIMEOUT  = 2000
) (
  input  logic                                clk,
  input  logic                                system_reset_n,
  input  logic                                input_button,
  input  logic                                store_button,
  input  logic                                submit_button,
  input  logic [DIGIT_W-1:0]                  digit_in,
  output logic                                unlock,
  output logic                                locked_out,
  output logic                                entering,
  output logic                                store_mode,
  output logic [$clog2(CODE_DIGITS+1)-1:0]    digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left,
  output logic                                fail_pulse,
  output logic                                store_done,
  output logic                                store_err
);

  localparam int CW = CODE_DIGITS * DIGIT_W;
  localparam int NW = count_width(CODE_DIGITS);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int TW = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT);

  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LOAD   = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [NW-1:0] FULL_COUNT   = NW'(CODE_DIGITS);
  localparam logic [AW-1:0] ATT_MAX      = AW'(MAX_ATTEMPTS);

  // bit 0 input, bit 1 store, bit 2 submit
  logic [2:0] btn_level;
  logic [2:0] btn_rise;

  assign btn_level = {submit_button, store_button, input_button};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    button_edge u_edge (
      .clk            (clk),
      .system_reset_n (system_reset_n),
      .level          (btn_level[gi]),
      .rise           (btn_rise[gi])
    );
  end

  logic submit_acc;
  logic store_acc;
  logic input_acc;

  assign submit_acc = btn_rise[2];
  assign store_acc  = btn_rise[1] & ~btn_rise[2];
  assign input_acc  = btn_rise[0] & ~btn_rise[1] & ~btn_rise[2];

  lock_state_t     state_reg;
  logic [CW-1:0]   code_reg;
  logic [CW-1:0]   entry_reg;
  logic            ovf_reg;
  logic [TW-1:0]   timer_reg;
  logic            entry_full;
  logic            code_match;

  assign entry_full = (digit_count == FULL_COUNT) && !ovf_reg;
  assign code_match = entry_full && (entry_reg == code_reg);

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_reg     <= IDLE;
      code_reg      <= DEFAULT_CODE;
      entry_reg     <= '0;
      ovf_reg       <= 1'b0;
      timer_reg     <= '0;
      digit_count   <= '0;
      attempts_left <= ATT_MAX;
      unlock        <= 1'b0;
      locked_out    <= 1'b0;
      entering      <= 1'b0;
      store_mode    <= 1'b0;
      fail_pulse    <= 1'b0;
      store_done    <= 1'b0;
      store_err     <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      store_done <= 1'b0;
      store_err  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (input_acc) begin
            entry_reg   <= CW'(digit_in);
            digit_count <= NW'(1);
            ovf_reg     <= 1'b0;
            timer_reg   <= ENTRY_LOAD;
            entering    <= 1'b1;
            state_reg   <= ENTRY;
          end
        end

        ENTRY, STORE_ENTRY: begin
          if (submit_acc) begin
            entering   <= 1'b0;
            store_mode <= 1'b0;
            if (state_reg == ENTRY) begin
              state_reg <= COMPARE;
            end else begin
              if (entry_full) begin
                code_reg   <= entry_reg;
                store_done <= 1'b1;
              end else begin
                store_err <= 1'b1;
              end
              entry_reg   <= '0;
              digit_count <= '0;
              ovf_reg     <= 1'b0;
              state_reg   <= IDLE;
            end
          end else if (input_acc) begin
            entry_reg <= (entry_reg << DIGIT_W) | CW'(digit_in);
            if (digit_count == FULL_COUNT) ovf_reg <= 1'b1;
            else                           digit_count <= digit_count + NW'(1);
            timer_reg <= ENTRY_LOAD;
          end else if (timer_reg == '0) begin
            // an abandoned plain entry is silent; an abandoned code change reports an error
            store_err   <= (state_reg == STORE_ENTRY);
            entry_reg   <= '0;
            digit_count <= '0;
            ovf_reg     <= 1'b0;
            entering    <= 1'b0;
            store_mode  <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end

        COMPARE: begin
          if (code_match) begin
            unlock        <= 1'b1;
            attempts_left <= ATT_MAX;
            timer_reg     <= UNLOCK_LOAD;
            state_reg     <= UNLOCKED;
          end else begin
            fail_pulse <= 1'b1;
            if (attempts_left == AW'(1)) begin
              attempts_left <= '0;
              locked_out    <= 1'b1;
              timer_reg     <= LOCKOUT_LOAD;
              state_reg     <= LOCKOUT;
            end else begin
              attempts_left <= attempts_left - AW'(1);
              state_reg     <= IDLE;
            end
          end
          entry_reg   <= '0;
          digit_count <= '0;
          ovf_reg     <= 1'b0;
        end

        UNLOCKED: begin
          if (submit_acc) begin
            unlock    <= 1'b0;
            state_reg <= IDLE;
          end else if (store_acc) begin
            unlock     <= 1'b0;
            entering   <= 1'b1;
            store_mode <= 1'b1;
            timer_reg  <= ENTRY_LOAD;
            state_reg  <= STORE_ENTRY;
          end else if (timer_reg == '0) begin
            unlock    <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end

        LOCKOUT: begin
          if (timer_reg == '0) begin
            locked_out    <= 1'b0;
            attempts_left <= ATT_MAX;
            state_reg     <= IDLE;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
